// File: rtl/scc_pkg.sv
// Shared definitions for the special-register-coupled fetch unit:
// fetch FSM encoding, parameter defaults and PC alignment helper.
package scc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEFAULT     = 4;
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/ack channel and decode valid/ready channel
// seen from the fetch unit (master) and from memory/decode (slave).
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch sequencer: reads PC from the special register file, fetches
// one word at a time, hands it to decode and writes back the next PC / LR.
module pc_fetch
  import scc_pkg::*;
#(
  parameter int unsigned PC_STEP     = PC_STEP_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] re_pc,
  output logic        wr_pc,
  output logic [31:0] wr_pc_data,
  output logic        wr_lr,
  output logic [31:0] wr_lr_data,
  pc_fetch_if.master  bus,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        branch_link,
  input  logic        halt,
  output logic        fault
);

  localparam int unsigned WCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           fault_lat_q, fault_lat_d;

  logic           imem_req_q, imem_req_d;
  logic [31:0]    imem_addr_q, imem_addr_d;
  logic           instr_valid_q, instr_valid_d;
  logic [31:0]    instr_q, instr_d;
  logic           wr_pc_d, wr_lr_d, fault_d;
  logic [31:0]    wr_pc_data_d, wr_lr_data_d;

  logic [31:0]    seq_pc, next_pc;

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      wait_q        <= '0;
      fault_lat_q   <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      wr_pc         <= 1'b0;
      wr_pc_data    <= '0;
      wr_lr         <= 1'b0;
      wr_lr_data    <= '0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wait_q        <= wait_d;
      fault_lat_q   <= fault_lat_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      wr_pc         <= wr_pc_d;
      wr_pc_data    <= wr_pc_data_d;
      wr_lr         <= wr_lr_d;
      wr_lr_data    <= wr_lr_data_d;
      fault         <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_d        = wait_q;
    fault_lat_d   = fault_lat_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    wr_pc_d       = 1'b0;
    wr_pc_data_d  = wr_pc_data;
    wr_lr_d       = 1'b0;
    wr_lr_data_d  = wr_lr_data;
    fault_d       = 1'b0;

    seq_pc  = pc_q + 32'(PC_STEP);
    next_pc = branch_valid ? word_align(branch_target) : seq_pc;

    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          pc_d        = word_align(re_pc);
          imem_req_d  = 1'b1;
          imem_addr_d = word_align(re_pc);
          wait_d      = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end else if (wait_q == WCW'(ACK_TIMEOUT - 1)) begin
          fault_d     = 1'b1;
          fault_lat_d = 1'b1;
          imem_req_d  = 1'b0;
          state_d     = HALTED;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          wr_pc_d       = 1'b1;
          wr_pc_data_d  = next_pc;
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          if (branch_valid && branch_link) begin
            wr_lr_d      = 1'b1;
            wr_lr_data_d = seq_pc;
          end
          if (halt) begin
            state_d = HALTED;
          end else begin
            imem_req_d  = 1'b1;
            imem_addr_d = next_pc;
            wait_d      = '0;
            state_d     = FETCH;
          end
        end
      end
      HALTED: begin
        // A timeout parks the unit here until reset.
        if (!fault_lat_q && !halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_pc_fetch;
  import scc_pkg::*;

  localparam int unsigned STEP = 4;
  localparam int unsigned TMO  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] re_pc;
  logic        wr_pc, wr_lr, fault;
  logic [31:0] wr_pc_data, wr_lr_data;
  logic        branch_valid, branch_link, halt;
  logic [31:0] branch_target;

  pc_fetch_if bus ();

  pc_fetch #(.PC_STEP(STEP), .ACK_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .re_pc        (re_pc),
    .wr_pc        (wr_pc),
    .wr_pc_data   (wr_pc_data),
    .wr_lr        (wr_lr),
    .wr_lr_data   (wr_lr_data),
    .bus          (bus),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .branch_link  (branch_link),
    .halt         (halt),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: what is outstanding, what is waiting for decode.
  bit          have_req, have_instr, stopped, dead;
  int unsigned waited;
  logic [31:0] m_pc, m_instr;
  bit          e_wrpc, e_wrlr, e_fault;
  logic [31:0] e_pcdata, e_lrdata;

  task automatic model_reset();
    have_req = 0; have_instr = 0; stopped = 0; dead = 0; waited = 0;
    m_pc = '0; m_instr = '0;
    e_wrpc = 0; e_wrlr = 0; e_fault = 0; e_pcdata = '0; e_lrdata = '0;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    e_wrpc = 0; e_wrlr = 0; e_fault = 0;
    if (dead) begin
    end else if (stopped) begin
      if (!halt) stopped = 0;
    end else if (have_req) begin
      if (bus.imem_ack) begin
        have_req = 0; have_instr = 1; m_instr = bus.imem_rdata;
      end else begin
        waited++;
        if (waited == TMO) begin
          have_req = 0; dead = 1; stopped = 1; e_fault = 1;
        end
      end
    end else if (have_instr) begin
      if (bus.instr_ready) begin
        nxt = branch_valid ? (branch_target & 32'hFFFF_FFFC) : m_pc + STEP;
        if (branch_valid && branch_link) begin
          e_wrlr = 1; e_lrdata = m_pc + STEP;
        end
        e_wrpc = 1; e_pcdata = nxt; m_pc = nxt; have_instr = 0;
        if (halt) stopped = 1;
        else begin have_req = 1; waited = 0; end
      end
    end else begin
      if (halt) stopped = 1;
      else begin m_pc = re_pc & 32'hFFFF_FFFC; have_req = 1; waited = 0; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_imem_req", 32'(bus.imem_req), 0);
      check("rst_imem_addr", bus.imem_addr, 0);
      check("rst_instr_valid", 32'(bus.instr_valid), 0);
      check("rst_instr", bus.instr, 0);
      check("rst_wr_pc", 32'(wr_pc), 0);
      check("rst_wr_pc_data", wr_pc_data, 0);
      check("rst_wr_lr", 32'(wr_lr), 0);
      check("rst_wr_lr_data", wr_lr_data, 0);
      check("rst_fault", 32'(fault), 0);
    end else begin
      check("imem_req", 32'(bus.imem_req), 32'(have_req));
      if (have_req) check("imem_addr", bus.imem_addr, m_pc);
      check("instr_valid", 32'(bus.instr_valid), 32'(have_instr));
      if (have_instr) check("instr", bus.instr, m_instr);
      check("wr_pc", 32'(wr_pc), 32'(e_wrpc));
      if (e_wrpc) check("wr_pc_data", wr_pc_data, e_pcdata);
      check("wr_lr", 32'(wr_lr), 32'(e_wrlr));
      if (e_wrlr) check("wr_lr_data", wr_lr_data, e_lrdata);
      check("fault", 32'(fault), 32'(e_fault));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
    branch_valid = 0; branch_target = '0; branch_link = 0; halt = 0;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1;
    quiet_inputs();
    re_pc = pc;
    cyc();
    reset = 0;
  endtask

  int unsigned stall = 0;
  int unsigned dead_cnt = 0;

  initial begin
    reset = 1;
    re_pc = '0;
    quiet_inputs();

    // Sequential fetch with 2-cycle ack latency.
    do_reset(32'h0000_0100);
    bus.instr_ready = 1;
    cyc();
    check("s1_req", 32'(bus.imem_req), 1);
    check("s1_addr", bus.imem_addr, 32'h0000_0100);
    cyc(); cyc();
    bus.imem_ack = 1; bus.imem_rdata = 32'h1111_2222;
    cyc();
    bus.imem_ack = 0;
    check("s1_valid", 32'(bus.instr_valid), 1);
    check("s1_instr", bus.instr, 32'h1111_2222);
    cyc();
    check("s1_wr_pc", 32'(wr_pc), 1);
    check("s1_wr_pc_data", wr_pc_data, 32'h0000_0104);
    check("s1_next_addr", bus.imem_addr, 32'h0000_0104);
    check("s1_next_req", 32'(bus.imem_req), 1);
    cyc();
    check("s1_wr_pc_pulse", 32'(wr_pc), 0);

    // Branch-and-link from pc 0x40.
    do_reset(32'h0000_0040);
    cyc();
    bus.imem_ack = 1; bus.imem_rdata = 32'h0BAD_0040;
    cyc();
    bus.imem_ack = 0;
    bus.instr_ready = 1; branch_valid = 1; branch_target = 32'h0000_2003; branch_link = 1;
    cyc();
    check("s2_wr_pc", 32'(wr_pc), 1);
    check("s2_wr_pc_data", wr_pc_data, 32'h0000_2000);
    check("s2_wr_lr", 32'(wr_lr), 1);
    check("s2_wr_lr_data", wr_lr_data, 32'h0000_0044);
    check("s2_addr", bus.imem_addr, 32'h0000_2000);
    bus.instr_ready = 0; branch_valid = 0; branch_link = 0;
    cyc();
    check("s2_wr_pc_pulse", 32'(wr_pc), 0);
    check("s2_wr_lr_pulse", 32'(wr_lr), 0);

    // Decode back-pressure for 5 cycles.
    bus.imem_ack = 1; bus.imem_rdata = 32'hCAFE_F00D;
    cyc();
    bus.imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("s3_valid", 32'(bus.instr_valid), 1);
      check("s3_instr", bus.instr, 32'hCAFE_F00D);
      check("s3_no_wr_pc", 32'(wr_pc), 0);
    end
    bus.instr_ready = 1;
    cyc();
    check("s3_wr_pc", 32'(wr_pc), 1);
    check("s3_wr_pc_data", wr_pc_data, 32'h0000_2004);
    bus.instr_ready = 0;

    // Ack timeout, then sticky halt.
    do_reset(32'h0000_0080);
    cyc();
    check("s4_req", 32'(bus.imem_req), 1);
    for (int i = 1; i <= 15; i++) begin
      cyc();
      check("s4_fault", 32'(fault), (i == 15) ? 1 : 0);
      check("s4_req_hold", 32'(bus.imem_req), (i == 15) ? 0 : 1);
    end
    cyc();
    check("s4_fault_pulse", 32'(fault), 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("s4_stuck", 32'(bus.imem_req), 0);
    end

    // PC wrap-around.
    do_reset(32'hFFFF_FFFE);
    cyc();
    check("s5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ack = 1; bus.imem_rdata = 32'h5555_AAAA; bus.instr_ready = 1;
    cyc();
    bus.imem_ack = 0;
    cyc();
    check("s5_wr_pc", 32'(wr_pc), 1);
    check("s5_wrap", wr_pc_data, 32'h0000_0000);
    check("s5_addr_wrap", bus.imem_addr, 32'h0000_0000);
    bus.instr_ready = 0;

    // Reset mid-fetch with a late ack.
    do_reset(32'h0000_0300);
    cyc();
    check("s6_req", 32'(bus.imem_req), 1);
    #2 reset = 1;
    #1;
    check("s6_async_req", 32'(bus.imem_req), 0);
    check("s6_async_addr", bus.imem_addr, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_0001; re_pc = 32'h0000_0500;
    cyc();
    reset = 0;
    cyc();
    check("s6_no_valid", 32'(bus.instr_valid), 0);
    check("s6_restart_req", 32'(bus.imem_req), 1);
    check("s6_restart_addr", bus.imem_addr, 32'h0000_0500);
    bus.imem_ack = 0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (dead) dead_cnt++; else dead_cnt = 0;
      reset = (dead_cnt > 4) || ($urandom_range(0, 299) == 0);
      if (c % 700 == 100) stall = 25;
      if (stall > 0) stall--;
      bus.imem_ack = (stall == 0) &&
                     (bus.imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
      bus.imem_rdata  = $urandom;
      bus.instr_ready = $urandom_range(0, 1) == 1;
      branch_valid    = $urandom_range(0, 2) == 0;
      branch_target   = $urandom;
      branch_link     = $urandom_range(0, 1) == 1;
      halt            = $urandom_range(0, 11) == 0;
      re_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    reset = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter PC_STEP, default 4, byte increment between sequential fetches.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, maximum wait cycles for imem_ack before fault.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port re_pc  input  32  current PC from the special register file (R6).
REQ-006 SHALL have port wr_pc  output  1  one-cycle PC write strobe to the special register file.
REQ-007 SHALL have port wr_pc_data  output  32  next PC value.
REQ-008 SHALL have port wr_lr  output  1  one-cycle LR (R5) write strobe.
REQ-009 SHALL have port wr_lr_data  output  32  return address.
REQ-010 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_ack (input, 1) and imem_rdata (input, 32), forming the instruction-memory request/ack channel.
REQ-011 SHALL have ports instr_valid (output, 1), instr (output, 32) and instr_ready (input, 1), forming the decode valid/ready channel.
REQ-012 SHALL have ports branch_valid (input, 1), branch_target (input, 32) and branch_link (input, 1), forming the redirect request.
REQ-013 SHALL have port halt  input  1  stop fetching at the next safe point.
REQ-014 SHALL have port fault  output  1  one-cycle pulse on instruction-memory timeout.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD, HALTED; all outputs registered.
REQ-016 IDLE: if halt=1 SHALL go to HALTED; else SHALL load pc_q = {re_pc[31:2],2'b00} and go to FETCH.
REQ-017 FETCH: SHALL drive imem_req=1 and imem_addr=pc_q, held stable until ack or timeout.
REQ-018 FETCH with imem_ack=1: SHALL capture imem_rdata into instr, set instr_valid=1 next cycle, and go to HOLD.
REQ-019 FETCH: wait counter SHALL count cycles without ack; when it reaches ACK_TIMEOUT, SHALL pulse fault, drop imem_req, and go to HALTED.
REQ-020 HOLD: SHALL hold instr and instr_valid stable until instr_ready=1.
REQ-021 HOLD with instr_ready=1 and branch_valid=0: SHALL pulse wr_pc with wr_pc_data = pc_q+PC_STEP (mod 2^32) and set pc_q to the same value.
REQ-022 HOLD with instr_ready=1 and branch_valid=1: SHALL use {branch_target[31:2],2'b00} as next PC; if branch_link=1, SHALL also pulse wr_lr with wr_lr_data = pc_q+PC_STEP.
REQ-023 On the HOLD handshake, SHALL drop instr_valid and go to HALTED if halt=1, else to FETCH.
REQ-024 branch_valid SHALL be ignored outside a HOLD handshake cycle.
REQ-025 halt during FETCH SHALL NOT abort the outstanding request; it takes effect at the next handshake.
REQ-026 HALTED: with halt=0 and the state not entered via fault, SHALL go to IDLE; after fault, SHALL leave HALTED only by reset.
REQ-027 Wrap-around: pc_q 0xFFFFFFFC + 4 SHALL produce 0x00000000, with no flag.
REQ-028 Latency: a request SHALL be issued 1 cycle after IDLE; instr_valid SHALL rise 1 cycle after ack; the next request SHALL be issued 1 cycle after the handshake.

Reset
REQ-029 Reset SHALL force state IDLE, pc_q=0, wait counter=0, fault-latch=0, and set every output to 0 immediately, independent of clk.
REQ-030 Reset mid-FETCH or mid-HOLD SHALL abandon the transaction; a late imem_ack after reset SHALL be ignored.

Structure
REQ-031 State encodings, PC_STEP default and ACK_TIMEOUT default SHALL reside in shared package scc_pkg.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Scenario: re_pc=0x100, ack after 2 cycles, ready immediate -> imem_addr=0x100, then wr_pc_data=0x104, next imem_addr=0x104.
REQ-034 Scenario: HOLD with branch_valid=1, target=0x2003, link=1, pc_q=0x40 -> wr_pc_data=0x2000, wr_lr_data=0x44, both single-cycle pulses.
REQ-035 Scenario: instr_ready low for 5 cycles -> instr and instr_valid stable throughout, no wr_pc until ready.
REQ-036 Scenario: no ack for 15 cycles -> fault pulses once, imem_req=0, state HALTED persists with halt=0 until reset.
REQ-037 Scenario: pc_q=0xFFFFFFFC, handshake -> wr_pc_data=0x00000000.
REQ-038 Scenario: reset asserted mid-FETCH, then ack arrives -> all outputs 0 asynchronously, no instr_valid, restart from re_pc.
